// File: rtl/core_pkg.sv
// Shared types for the core pipeline hazard logic.
// Holds forwarding select encoding, stage tag struct and register width.
package core_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_AW   = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
    logic              is_load;
  } hz_tag_t;

endpackage

// File: rtl/core_hazard_ctrl_if.sv
// ID-stage decode / hazard control bundle for core_hazard_ctrl.
// master drives decode fields and reads controls; slave is the controller.
// With CORE_HAZARD_PERF_EN, o_stall_cnt/o_flush_cnt are added.
interface core_hazard_ctrl_if;

  logic                         i_id_valid;
  logic                         i_src1_reg_en;
  logic                         i_src2_reg_en;
  logic [core_pkg::REG_AW-1:0]  i_src1_reg_addr;
  logic [core_pkg::REG_AW-1:0]  i_src2_reg_addr;
  logic [core_pkg::REG_AW-1:0]  i_dst_reg_addr;
  logic                         i_reg_write;
  logic                         i_memory2reg;
  logic                         i_ex_redirect;
  logic                         i_mem_ready;
  logic                         o_stall_if;
  logic                         o_stall_id;
  logic                         o_bubble_ex;
  logic                         o_flush_id;
  logic                         o_freeze;
  logic [1:0]                   o_fwd_src1;
  logic [1:0]                   o_fwd_src2;
`ifdef CORE_HAZARD_PERF_EN
  logic [31:0]                  o_stall_cnt;
  logic [31:0]                  o_flush_cnt;

  modport master (
    output i_id_valid, i_src1_reg_en, i_src2_reg_en,
    output i_src1_reg_addr, i_src2_reg_addr, i_dst_reg_addr,
    output i_reg_write, i_memory2reg, i_ex_redirect, i_mem_ready,
    input  o_stall_if, o_stall_id, o_bubble_ex, o_flush_id,
    input  o_freeze, o_fwd_src1, o_fwd_src2,
    input  o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_valid, i_src1_reg_en, i_src2_reg_en,
    input  i_src1_reg_addr, i_src2_reg_addr, i_dst_reg_addr,
    input  i_reg_write, i_memory2reg, i_ex_redirect, i_mem_ready,
    output o_stall_if, o_stall_id, o_bubble_ex, o_flush_id,
    output o_freeze, o_fwd_src1, o_fwd_src2,
    output o_stall_cnt, o_flush_cnt
  );
`else
  modport master (
    output i_id_valid, i_src1_reg_en, i_src2_reg_en,
    output i_src1_reg_addr, i_src2_reg_addr, i_dst_reg_addr,
    output i_reg_write, i_memory2reg, i_ex_redirect, i_mem_ready,
    input  o_stall_if, o_stall_id, o_bubble_ex, o_flush_id,
    input  o_freeze, o_fwd_src1, o_fwd_src2
  );

  modport slave (
    input  i_id_valid, i_src1_reg_en, i_src2_reg_en,
    input  i_src1_reg_addr, i_src2_reg_addr, i_dst_reg_addr,
    input  i_reg_write, i_memory2reg, i_ex_redirect, i_mem_ready,
    output o_stall_if, o_stall_id, o_bubble_ex, o_flush_id,
    output o_freeze, o_fwd_src1, o_fwd_src2
  );
`endif

endinterface

// File: rtl/core_fwd_match.sv
// Per-source comparator against EX/MEM/WB tags.
// Ports: i_ex/i_mem/i_wb tags, i_src, i_src_en -> o_fwd_sel, o_load_hit.
module core_fwd_match
  import core_pkg::*;
(
  input  hz_tag_t           i_ex,
  input  hz_tag_t           i_mem,
  input  hz_tag_t           i_wb,
  input  logic [REG_AW-1:0] i_src,
  input  logic              i_src_en,
  output fwd_sel_e          o_fwd_sel,
  output logic              o_load_hit
);

  logic w_rd;
  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;

  assign w_rd      = i_src_en && (i_src != '0);
  assign w_hit_ex  = w_rd && i_ex.valid  && (i_ex.dst  == i_src);
  assign w_hit_mem = w_rd && i_mem.valid && (i_mem.dst == i_src);
  assign w_hit_wb  = w_rd && i_wb.valid  && (i_wb.dst  == i_src);

  // Youngest producer wins; a load only blocks when it is that producer.
  always_comb begin
    o_fwd_sel  = FWD_RF;
    o_load_hit = 1'b0;
    if (w_hit_ex) begin
      o_fwd_sel  = FWD_EX;
      o_load_hit = i_ex.is_load;
    end else if (w_hit_mem) begin
      o_fwd_sel  = FWD_MEM;
      o_load_hit = i_mem.is_load;
    end else if (w_hit_wb) begin
      o_fwd_sel  = FWD_WB;
    end
  end

endmodule

// File: rtl/core_hazard_ctrl.sv
// 5-stage pipeline hazard controller: stall/bubble/flush/freeze + forwarding.
// Ports: i_clk, i_rst_n, hz (slave). CORE_HAZARD_PERF_EN adds perf counters.
module core_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned NUM_REGS = core_pkg::NUM_REGS,
  parameter int unsigned REG_AW   = core_pkg::REG_AW
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  core_hazard_ctrl_if.slave hz
);

  hz_tag_t  r_ex;
  hz_tag_t  r_mem;
  hz_tag_t  r_wb;
  hz_tag_t  w_id_tag;
  fwd_sel_e w_sel1;
  fwd_sel_e w_sel2;
  logic     w_hit1;
  logic     w_hit2;
  logic     w_load_use;
  logic     w_issue;
  logic     w_dst_ok;
  logic     w_stall;
  logic     w_bubble;
  logic     w_flush;
  logic     w_freeze;

  assign w_dst_ok = (hz.i_dst_reg_addr != REG_AW'(0)) &&
                    (32'(hz.i_dst_reg_addr) < NUM_REGS);

  assign w_id_tag = '{
    valid:   hz.i_reg_write && w_dst_ok,
    dst:     hz.i_dst_reg_addr,
    is_load: hz.i_memory2reg
  };

  core_fwd_match u_match1 (
    .i_ex       (r_ex),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .i_src      (hz.i_src1_reg_addr),
    .i_src_en   (hz.i_src1_reg_en),
    .o_fwd_sel  (w_sel1),
    .o_load_hit (w_hit1)
  );

  core_fwd_match u_match2 (
    .i_ex       (r_ex),
    .i_mem      (r_mem),
    .i_wb       (r_wb),
    .i_src      (hz.i_src2_reg_addr),
    .i_src_en   (hz.i_src2_reg_en),
    .o_fwd_sel  (w_sel2),
    .o_load_hit (w_hit2)
  );

  assign w_load_use = w_hit1 | w_hit2;
  assign w_issue    = hz.i_id_valid & ~w_load_use & ~hz.i_ex_redirect;

  // Memory freeze outranks a redirect: EX holds the redirect until it ends.
  always_comb begin
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    w_freeze = 1'b0;
    if (!hz.i_mem_ready) begin
      w_freeze = 1'b1;
      w_stall  = 1'b1;
    end else if (hz.i_ex_redirect) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
    end else if (w_load_use && hz.i_id_valid) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (hz.i_mem_ready) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= w_issue ? w_id_tag : '0;
    end
  end

  // Outputs read 0 while reset is held, independent of ID inputs.
  assign hz.o_stall_if  = i_rst_n & w_stall;
  assign hz.o_stall_id  = i_rst_n & w_stall;
  assign hz.o_bubble_ex = i_rst_n & w_bubble;
  assign hz.o_flush_id  = i_rst_n & w_flush;
  assign hz.o_freeze    = i_rst_n & w_freeze;
  assign hz.o_fwd_src1  = i_rst_n ? w_sel1 : 2'd0;
  assign hz.o_fwd_src2  = i_rst_n ? w_sel2 : 2'd0;

`ifdef CORE_HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign hz.o_stall_cnt = r_stall_cnt;
  assign hz.o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_core_hazard_ctrl.sv
// Directed vector bench for core_hazard_ctrl.
// Checks controls and forwarding per cycle; perf counters when enabled.
module tb_core_hazard_ctrl;

  typedef struct {
    string       nm;
    logic        idv;
    logic        e1;
    logic        e2;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  dst;
    logic        rw;
    logic        ld;
    logic        rdr;
    logic        mrdy;
    logic [8:0]  exp;
  } vec_t;

  // {stall_if, stall_id, bubble_ex, flush_id, freeze}
  localparam logic [4:0] C0  = 5'b00000;
  localparam logic [4:0] CST = 5'b11100;
  localparam logic [4:0] CFL = 5'b00110;
  localparam logic [4:0] CFR = 5'b11001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  vec_t vq[$];

  core_hazard_ctrl_if hz ();

  core_hazard_ctrl dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .hz      (hz)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    string nm, logic idv, logic e1, logic e2,
    int s1, int s2, int dst, logic rw, logic ld,
    logic rdr, logic mrdy, logic [4:0] ctl,
    int f1, int f2
  );
    vec_t v;
    v.nm = nm;   v.idv = idv; v.e1 = e1; v.e2 = e2;
    v.s1 = 5'(s1); v.s2 = 5'(s2); v.dst = 5'(dst);
    v.rw = rw;   v.ld = ld;   v.rdr = rdr; v.mrdy = mrdy;
    v.exp = {ctl, 2'(f1), 2'(f2)};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    hz.i_id_valid      = v.idv;
    hz.i_src1_reg_en   = v.e1;
    hz.i_src2_reg_en   = v.e2;
    hz.i_src1_reg_addr = v.s1;
    hz.i_src2_reg_addr = v.s2;
    hz.i_dst_reg_addr  = v.dst;
    hz.i_reg_write     = v.rw;
    hz.i_memory2reg    = v.ld;
    hz.i_ex_redirect   = v.rdr;
    hz.i_mem_ready     = v.mrdy;
  endtask

  function automatic logic [8:0] outs();
    return {hz.o_stall_if, hz.o_stall_id, hz.o_bubble_ex,
            hz.o_flush_id, hz.o_freeze,
            hz.o_fwd_src1, hz.o_fwd_src2};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    #2;
    chk(v.nm, 32'(outs()), 32'(v.exp));
  endtask

  initial begin
    vec_t idle;
    vec_t cons;
    idle = mk("idle", 0,0,0, 0,0,0, 0,0,0,1, C0,0,0);
    drive(idle);
    hz.i_id_valid = 1'b1;
    hz.i_mem_ready = 1'b0;
    #3;
    chk("reset_outs", 32'(outs()), 32'd0);
`ifdef CORE_HAZARD_PERF_EN
    chk("reset_scnt", hz.o_stall_cnt, 32'd0);
    chk("reset_fcnt", hz.o_flush_cnt, 32'd0);
`endif
    @(negedge clk);
    drive(idle);
    rst_n = 1'b1;

    vq.push_back(mk("alu_prod", 1,1,1, 1,2,5,  1,0,0,1, C0, 0,0));
    vq.push_back(mk("fwd_ex",   1,1,1, 5,1,6,  1,0,0,1, C0, 1,0));
    vq.push_back(mk("fwd_mem",  1,1,1, 5,0,7,  1,0,0,1, C0, 2,0));
    vq.push_back(mk("fwd_wb",   1,1,1, 5,6,8,  1,0,0,1, C0, 3,2));
    vq.push_back(mk("src_dis",  1,0,0, 7,8,0,  0,0,0,1, C0, 0,0));
    vq.push_back(mk("idle0",    0,0,0, 0,0,0,  0,0,0,1, C0, 0,0));
    vq.push_back(mk("idle1",    0,0,0, 0,0,0,  0,0,0,1, C0, 0,0));
    vq.push_back(mk("lw_x5",    1,1,0, 1,0,5,  1,1,0,1, C0, 0,0));
    vq.push_back(mk("lu_st1",   1,1,1, 5,5,6,  1,0,0,1, CST,1,1));
    vq.push_back(mk("lu_st2",   1,1,1, 5,5,6,  1,0,0,1, CST,2,2));
    vq.push_back(mk("lu_issue", 1,1,1, 5,5,6,  1,0,0,1, C0, 3,3));
    vq.push_back(mk("lw_x0",    1,1,0, 1,0,0,  1,1,0,1, C0, 0,0));
    vq.push_back(mk("use_x0",   1,1,1, 0,0,9,  1,0,0,1, C0, 0,0));
    vq.push_back(mk("lw_x10",   1,0,0, 0,0,10, 1,1,0,1, C0, 0,0));
    vq.push_back(mk("redir",    1,1,0, 10,0,11,1,0,1,1, CFL,1,0));
    vq.push_back(mk("post_rd",  1,1,1, 11,10,12,1,0,0,1,CST,0,2));
    vq.push_back(mk("post_iss", 1,1,1, 11,10,12,1,0,0,1,C0, 0,3));
    vq.push_back(mk("lw_x13",   1,1,0, 12,0,13,1,1,0,1, C0, 1,0));
    vq.push_back(mk("idle2",    0,0,0, 0,0,0,  0,0,0,1, C0, 0,0));
    vq.push_back(mk("frz1",     1,1,1, 13,12,14,1,0,1,0,CFR,2,3));
    vq.push_back(mk("frz2",     1,1,1, 13,12,14,1,0,1,0,CFR,2,3));
    vq.push_back(mk("frz3",     1,1,1, 13,12,14,1,0,1,0,CFR,2,3));
    vq.push_back(mk("frz_lu",   1,1,1, 13,12,14,1,0,0,1,CST,2,3));
    vq.push_back(mk("frz_iss",  1,1,1, 13,12,14,1,0,0,1,C0, 3,0));

    foreach (vq[i]) apply(vq[i]);

`ifdef CORE_HAZARD_PERF_EN
    chk("stall_cnt", hz.o_stall_cnt, 32'd7);
    chk("flush_cnt", hz.o_flush_cnt, 32'd1);
`endif

    apply(idle);
    apply(idle);
    apply(idle);
    apply(mk("rst_lw", 1,1,0, 1,0,5, 1,1,0,1, C0,0,0));
    cons = mk("rst_cons", 1,1,1, 5,5,6, 1,0,0,1, CST,1,1);
    apply(cons);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(outs()), 32'd0);
`ifdef CORE_HAZARD_PERF_EN
    chk("rst_scnt", hz.o_stall_cnt, 32'd0);
    chk("rst_fcnt", hz.o_flush_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("post_rst", 32'(outs()), 32'd0);
    @(negedge clk);
    drive(idle);
    #2;
    chk("post_rst_idle", 32'(outs()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/core_hazard_ctrl.md
Name: core_hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core (IF/ID/EX/MEM/WB).
- Takes the ID-stage decode fields and keeps per-stage destination tags for EX, MEM and WB.
- From these it generates stall, bubble and flush controls plus operand forwarding selects, and it sequences the ID→EX issue for each instruction.

Parameters:
- NUM_REGS, 32, architectural register count; register 0 is hard-wired zero.
- REG_AW, 5, register address width (log2 NUM_REGS).

Ports:
- i_clk  input  1  core clock
- i_rst_n  input  1  asynchronous active-low reset
- i_id_valid  input  1  ID holds a valid instruction
- i_src1_reg_en  input  1  ID reads rs1
- i_src2_reg_en  input  1  ID reads rs2
- i_src1_reg_addr  input  REG_AW  rs1
- i_src2_reg_addr  input  REG_AW  rs2
- i_dst_reg_addr  input  REG_AW  rd
- i_reg_write  input  1  ID instruction writes rd (alures2reg | memory2reg)
- i_memory2reg  input  1  ID instruction is a load
- i_ex_redirect  input  1  EX resolved a taken branch, jal or jalr
- i_mem_ready  input  1  data memory done; 0 freezes the pipeline
- o_stall_if  output  1  hold PC
- o_stall_id  output  1  hold IF/ID register
- o_bubble_ex  output  1  insert NOP into ID/EX
- o_flush_id  output  1  kill IF/ID contents
- o_freeze  output  1  hold EX/MEM/WB registers
- o_fwd_src1  output  2  rs1 source: 0 regfile, 1 EX result, 2 MEM result, 3 WB result
- o_fwd_src2  output  2  rs2 source, same encoding

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: all tags invalid; all outputs 0. Reset asserted mid-operation clears tags immediately; the first cycle after release shows no stall.
- Tag contents (EX, MEM, WB): {valid, dst, is_load}. Valid means reg_write=1 and dst≠0.
- Match definition: src_en=1, src≠0, tag valid, tag.dst==src.
- Forward select: combinational. Priority EX > MEM > WB; otherwise 0.
- Load-use: a match against an EX or MEM tag with is_load=1 sets load_use=1. Load data is forwardable only from WB.
- Control decode, evaluated in priority order:
  - i_mem_ready=0: o_freeze=o_stall_if=o_stall_id=1, no bubble, tags hold. i_ex_redirect is ignored; EX keeps it asserted until the freeze ends.
  - i_ex_redirect=1: o_flush_id=1 and o_bubble_ex=1, no stall. Redirect overrides load_use.
  - load_use & i_id_valid: o_stall_if=o_stall_id=o_bubble_ex=1.
  - Otherwise all controls are 0.
- Tag advance, on edges where i_mem_ready=1: WB<=MEM, MEM<=EX, and EX<=issue ? ID tag : invalid.
  - issue = i_id_valid & ~load_use & ~i_ex_redirect.
- Timing: a load followed by a dependent instruction stalls exactly 2 cycles; the dependent instruction then issues with fwd=3. An ALU dependency has 0 stall cycles.
- Redirect latency: 1 cycle. The wrong-path ID instruction never enters EX.
- Writes to x0 never create hazards.

Optional Feature:
- Macro: CORE_HAZARD_PERF_EN.
- When defined: adds outputs o_stall_cnt[31:0] and o_flush_cnt[31:0].
  - o_stall_cnt increments on each cycle with load_use stall or freeze.
  - o_flush_cnt increments on each redirect accepted (i_ex_redirect & i_mem_ready).
  - Both counters wrap at 2^32 and reset to 0.
- When undefined: the ports and counters do not exist.

Decomposition:
- Shared package core_pkg holds:
  - fwd_sel_e enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB}
  - hz_tag_t struct {valid, dst, is_load}
  - REG_AW constant
- One sub-module, core_fwd_match: per-source comparator taking the 3 tags, src, src_en; returns fwd_sel and load_hit. It is instantiated twice.

Test Plan:
- add x5 then add x6,x5,x1 back-to-back → o_fwd_src1=1, no stall. One instruction gap → 2; two gaps → 3.
- lw x5 then add x6,x5,x5 → 2 cycles of stall_if/stall_id/bubble_ex=1, then issue with o_fwd_src1=o_fwd_src2=3.
- lw x0 then use of x0 → no stall, fwd=0. add writing x7, consumer with src_en=0 → fwd=0.
- beq taken (i_ex_redirect=1) while ID holds a load-use consumer → flush_id=1, bubble_ex=1, stall=0; the EX tag after the edge is invalid.
- i_mem_ready=0 for 3 cycles with a load in MEM → freeze=1 for 3 cycles, tags unchanged, then advance resumes normally.
- Assert i_rst_n=0 mid-stall → all outputs 0 asynchronously; with CORE_HAZARD_PERF_EN, after a load-use plus one redirect, o_stall_cnt=2 and o_flush_cnt=1.
